// File: rtl/axi_elastic_buffer.sv
// axi_elastic_buffer
//   Depth-entry circular buffer with valid/ready handshakes on both sides, used
//   on AXI channel paths. ready_o depends only on the fill level, never on
//   ready_i, so the ready path is cut. With FallThrough=1 an empty buffer
//   passes the upstream beat straight through in the same cycle.
//
//   Optional feature macro: AXI_ELASTIC_BUFFER_STATS_EN
//     adds stall_cnt_o (saturating stall-cycle counter) and max_cnt_o
//     (high-water mark of the fill level).
//
// Ports
//   clk_i    clock, rising edge
//   rst_i    synchronous active-high reset
//   flush_i  synchronous clear of all stored entries (contents kept)
//   valid_i / ready_o / data_i   upstream handshake and payload
//   valid_o / ready_i / data_o   downstream handshake and payload
//   count_o  number of stored entries
module axi_elastic_buffer #(
    parameter int unsigned DataWidth   = 32,
    parameter int unsigned Depth       = 2,
    parameter int unsigned FallThrough = 0,
    parameter int unsigned CntWidth    = $clog2(Depth + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 flush_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    input  logic [DataWidth-1:0] data_i,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic [DataWidth-1:0] data_o,
    output logic [CntWidth-1:0]  count_o
`ifdef AXI_ELASTIC_BUFFER_STATS_EN
    ,
    output logic [31:0]          stall_cnt_o,
    output logic [CntWidth-1:0]  max_cnt_o
`endif
);

    localparam int unsigned         PtrW    = (Depth > 1) ? $clog2(Depth) : 1;
    localparam logic [PtrW-1:0]     LastPtr = PtrW'(Depth - 1);
    localparam logic [CntWidth-1:0] Full    = CntWidth'(Depth);

    logic [DataWidth-1:0] mem_q [Depth];
    logic [PtrW-1:0]      wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CntWidth-1:0]  cnt_q, cnt_d;

    logic empty, ft_pass, bypass, push, pop, wr_en, rd_en;

    assign empty   = (cnt_q == '0);
    // Output is driven straight from the input only when empty in fall-through mode.
    assign ft_pass = (FallThrough != 0) & empty;
    assign ready_o = (cnt_q != Full) & ~rst_i;
    assign valid_o = ~rst_i & (ft_pass ? valid_i : ~empty);
    assign data_o  = ft_pass ? data_i : mem_q[rptr_q];
    assign count_o = cnt_q;

    assign push   = valid_i & ready_o;
    assign pop    = valid_o & ready_i;
    // A beat consumed in the same cycle it arrives at an empty buffer is never stored.
    assign bypass = ft_pass & valid_i & ready_i;
    assign wr_en  = push & ~bypass;
    assign rd_en  = pop & ~bypass;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (flush_i) begin
            wptr_d = '0;
            rptr_d = '0;
            cnt_d  = '0;
        end else begin
            if (wr_en) wptr_d = (wptr_q == LastPtr) ? '0 : wptr_q + 1'b1;
            if (rd_en) rptr_d = (rptr_q == LastPtr) ? '0 : rptr_q + 1'b1;
            cnt_d = cnt_q + CntWidth'(wr_en) - CntWidth'(rd_en);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
            for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
            if (wr_en && !flush_i) mem_q[wptr_q] <= data_i;
        end
    end

`ifdef AXI_ELASTIC_BUFFER_STATS_EN
    logic [31:0]         stall_q;
    logic [CntWidth-1:0] max_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_q <= '0;
            max_q   <= '0;
        end else begin
            if (flush_i)                                     stall_q <= '0;
            else if (valid_o && !ready_i && stall_q != '1)   stall_q <= stall_q + 32'd1;
            // Track next-state so max_cnt_o never lags count_o.
            if (cnt_d > max_q) max_q <= cnt_d;
        end
    end

    assign stall_cnt_o = stall_q;
    assign max_cnt_o   = max_q;
`endif

`ifndef SYNTHESIS
    a_cnt_range: assert property (@(posedge clk_i) cnt_q <= Full);
    a_no_push_full: assert property (@(posedge clk_i) disable iff (rst_i)
        !(push && cnt_q == Full));
    a_valid_stable: assert property (@(posedge clk_i) disable iff (rst_i)
        (valid_i && !ready_o) |=> valid_i);
`endif

endmodule

// File: tb/tb_axi_elastic_buffer.sv
module tb_axi_elastic_buffer;
    localparam int DW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, vin, rin, flush;
    logic [DW-1:0] din;
    int sel;

    logic [3:0] v_i, rdy, vld;
    logic [DW-1:0] dat [4];
    logic [1:0] c0, c1, c3;
    logic [2:0] c2;
`ifdef AXI_ELASTIC_BUFFER_STATS_EN
    logic [31:0] st [4];
    logic [1:0] m0, m1, m3;
    logic [2:0] m2;
`endif

    // Only the instance under test sees valid_i; the others stay idle.
    always_comb for (int k = 0; k < 4; k++) v_i[k] = vin && (sel == k);

    axi_elastic_buffer #(.DataWidth(DW), .Depth(2), .FallThrough(0)) u0 (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .valid_i(v_i[0]), .ready_o(rdy[0]),
        .data_i(din), .valid_o(vld[0]), .ready_i(rin), .data_o(dat[0]), .count_o(c0)
`ifdef AXI_ELASTIC_BUFFER_STATS_EN
        , .stall_cnt_o(st[0]), .max_cnt_o(m0)
`endif
    );
    axi_elastic_buffer #(.DataWidth(DW), .Depth(3), .FallThrough(0)) u1 (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .valid_i(v_i[1]), .ready_o(rdy[1]),
        .data_i(din), .valid_o(vld[1]), .ready_i(rin), .data_o(dat[1]), .count_o(c1)
`ifdef AXI_ELASTIC_BUFFER_STATS_EN
        , .stall_cnt_o(st[1]), .max_cnt_o(m1)
`endif
    );
    axi_elastic_buffer #(.DataWidth(DW), .Depth(4), .FallThrough(0)) u2 (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .valid_i(v_i[2]), .ready_o(rdy[2]),
        .data_i(din), .valid_o(vld[2]), .ready_i(rin), .data_o(dat[2]), .count_o(c2)
`ifdef AXI_ELASTIC_BUFFER_STATS_EN
        , .stall_cnt_o(st[2]), .max_cnt_o(m2)
`endif
    );
    axi_elastic_buffer #(.DataWidth(DW), .Depth(2), .FallThrough(1)) u3 (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .valid_i(v_i[3]), .ready_o(rdy[3]),
        .data_i(din), .valid_o(vld[3]), .ready_i(rin), .data_o(dat[3]), .count_o(c3)
`ifdef AXI_ELASTIC_BUFFER_STATS_EN
        , .stall_cnt_o(st[3]), .max_cnt_o(m3)
`endif
    );

    logic o_v, o_r;
    logic [DW-1:0] o_d;
    int o_c;
    always_comb begin
        o_v = vld[sel]; o_r = rdy[sel]; o_d = dat[sel];
        case (sel)
            0:       o_c = int'(c0);
            1:       o_c = int'(c1);
            2:       o_c = int'(c2);
            default: o_c = int'(c3);
        endcase
    end

    int errs = 0, checks = 0;

    // Behavioural model: a FIFO queue of accepted beats.
    logic [DW-1:0] mq[$];
    logic [DW-1:0] dq[$];   // beats the DUT actually handed downstream

    function automatic int dep();
        case (sel) 0: return 2; 1: return 3; 2: return 4; default: return 2; endcase
    endfunction
    function automatic bit m_byp();   return (sel == 3) && mq.size() == 0; endfunction
    function automatic bit m_ready(); return !rst && mq.size() < dep(); endfunction
    function automatic bit m_valid();
        if (rst) return 1'b0;
        if (m_byp()) return vin;
        return mq.size() > 0;
    endfunction
    function automatic logic [DW-1:0] m_data();
        if (m_byp()) return din;
        if (mq.size() == 0) return '0;
        return mq[0];
    endfunction
    function automatic int m_cnt(); return mq.size(); endfunction

    // Advance one clock edge, updating the model from the pre-edge inputs.
    task automatic tick();
        bit p, q, b;
        logic [DW-1:0] d;
        p = vin && m_ready();
        q = m_valid() && rin;
        b = m_byp() && vin && rin;
        d = din;
        if (o_v && rin && !rst) dq.push_back(o_d);
        @(posedge clk);
        if (rst || flush) mq.delete();
        else if (!b) begin
            if (q) void'(mq.pop_front());
            if (p) mq.push_back(d);
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        vin = 1'b0; rin = 1'b0; flush = 1'b0;
        tick();
        rst = 1'b0;
        dq.delete();
    endtask

    task automatic test_reset();
        sel = 2; rst = 1'b1; vin = 1'b0; rin = 1'b1;
        #1;
        checks++; if (o_r !== 1'b0) begin errs++; $display("FAIL reset_ready_in_rst: got %b exp 0", o_r); end
        checks++; if (o_v !== 1'b0) begin errs++; $display("FAIL reset_valid_in_rst: got %b exp 0", o_v); end
        tick(); tick();
        rst = 1'b0; rin = 1'b0; dq.delete();
        #1;
        checks++; if (o_r !== 1'b1) begin errs++; $display("FAIL reset_ready: got %b exp 1", o_r); end
        checks++; if (o_v !== 1'b0) begin errs++; $display("FAIL reset_valid: got %b exp 0", o_v); end
        checks++; if (o_c !== 0) begin errs++; $display("FAIL reset_count: got %0d exp 0", o_c); end
        checks++; if (o_d !== '0) begin errs++; $display("FAIL reset_data: got %h exp 0", o_d); end
    endtask

    task automatic test_back_to_back();
        sel = 0; do_reset(); rin = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            vin = 1'b1; din = DW'(i);
            #1;
            checks++; if (o_r !== 1'b1) begin errs++; $display("FAIL b2b_ready[%0d]: got %b exp 1", i, o_r); end
            checks++; if (o_v !== (i > 1)) begin errs++; $display("FAIL b2b_valid[%0d]: got %b exp %b", i, o_v, i > 1); end
            checks++; if (o_c > 1) begin errs++; $display("FAIL b2b_count[%0d]: got %0d exp <=1", i, o_c); end
            tick();
        end
        vin = 1'b0;
        #1;
        checks++; if (o_v !== 1'b1 || o_d !== 32'h8) begin errs++; $display("FAIL b2b_last: got v=%b d=%h exp v=1 d=8", o_v, o_d); end
        tick();
        checks++; if (dq.size() != 8) begin errs++; $display("FAIL b2b_num: got %0d exp 8", dq.size()); end
        for (int i = 0; i < dq.size() && i < 8; i++) begin
            checks++; if (dq[i] !== DW'(i + 1)) begin errs++; $display("FAIL b2b_order[%0d]: got %h exp %h", i, dq[i], i + 1); end
        end
    endtask

    task automatic test_fill_drain();
        int k;
        sel = 2; do_reset(); rin = 1'b0;
        for (k = 0; k < 4; k++) begin
            vin = 1'b1; din = 32'hA0 + DW'(k);
            #1;
            checks++; if (o_r !== 1'b1) begin errs++; $display("FAIL fill_ready[%0d]: got %b exp 1", k, o_r); end
            tick();
        end
        din = 32'hA4;
        #1;
        checks++; if (o_r !== 1'b0) begin errs++; $display("FAIL full_ready: got %b exp 0", o_r); end
        checks++; if (o_c !== 4) begin errs++; $display("FAIL full_count: got %0d exp 4", o_c); end
        checks++; if (o_v !== 1'b1 || o_d !== 32'hA0) begin errs++; $display("FAIL full_head: got v=%b d=%h exp v=1 d=a0", o_v, o_d); end
        tick();
        rin = 1'b1;
        for (int c = 0; c < 40 && dq.size() < 6; c++) begin
            bit acc;
            #1;
            checks++; if (o_r !== m_ready() || o_v !== m_valid() || o_c !== m_cnt())
                begin errs++; $display("FAIL drain_hs[%0d]: got r=%b v=%b c=%0d exp r=%b v=%b c=%0d", c, o_r, o_v, o_c, m_ready(), m_valid(), m_cnt()); end
            acc = vin && o_r;
            tick();
            if (acc) begin k++; if (k < 6) din = 32'hA0 + DW'(k); else vin = 1'b0; end
        end
        checks++; if (dq.size() != 6) begin errs++; $display("FAIL drain_num: got %0d exp 6", dq.size()); end
        for (int i = 0; i < dq.size(); i++) begin
            checks++; if (dq[i] !== 32'hA0 + DW'(i)) begin errs++; $display("FAIL drain_order[%0d]: got %h exp %h", i, dq[i], 32'hA0 + i); end
        end
        vin = 1'b0;
    endtask

    task automatic test_wrap();
        int k;
        sel = 1; do_reset(); rin = 1'b0;
        for (k = 0; k < 3; k++) begin vin = 1'b1; din = 32'h10 + DW'(k); tick(); end
        din = 32'h13; rin = 1'b1;
        for (int c = 0; c < 10; c++) begin
            bit acc;
            #1;
            checks++; if (o_r !== (c != 0)) begin errs++; $display("FAIL wrap_ready[%0d]: got %b exp %b", c, o_r, c != 0); end
            checks++; if (o_v !== m_valid() || o_d !== m_data()) begin errs++; $display("FAIL wrap_out[%0d]: got v=%b d=%h exp v=%b d=%h", c, o_v, o_d, m_valid(), m_data()); end
            acc = vin && o_r;
            tick();
            if (acc) begin k++; din = 32'h10 + DW'(k); end
        end
        vin = 1'b0;
        for (int c = 0; c < 10 && m_valid(); c++) tick();
        #1;
        checks++; if (o_v !== 1'b0) begin errs++; $display("FAIL wrap_drained: got %b exp 0", o_v); end
        checks++; if (k != 12 || dq.size() != 12) begin errs++; $display("FAIL wrap_num: got pushed=%0d popped=%0d exp 12", k, dq.size()); end
        for (int i = 0; i < dq.size(); i++) begin
            checks++; if (dq[i] !== 32'h10 + DW'(i)) begin errs++; $display("FAIL wrap_order[%0d]: got %h exp %h", i, dq[i], 32'h10 + i); end
        end
    endtask

    task automatic test_fallthrough();
        sel = 3; do_reset();
        vin = 1'b1; din = 32'h55; rin = 1'b1;
        #1;
        checks++; if (o_v !== 1'b1 || o_d !== 32'h55) begin errs++; $display("FAIL ft_pass: got v=%b d=%h exp v=1 d=55", o_v, o_d); end
        checks++; if (o_c !== 0) begin errs++; $display("FAIL ft_pass_cnt0: got %0d exp 0", o_c); end
        tick();
        checks++; if (o_c !== 0) begin errs++; $display("FAIL ft_pass_cnt1: got %0d exp 0", o_c); end
        din = 32'h66; rin = 1'b0;
        #1;
        checks++; if (o_v !== 1'b1 || o_d !== 32'h66) begin errs++; $display("FAIL ft_stall: got v=%b d=%h exp v=1 d=66", o_v, o_d); end
        tick();
        vin = 1'b0;
        #1;
        checks++; if (o_c !== 1) begin errs++; $display("FAIL ft_store_cnt: got %0d exp 1", o_c); end
        checks++; if (o_v !== 1'b1 || o_d !== 32'h66) begin errs++; $display("FAIL ft_store_out: got v=%b d=%h exp v=1 d=66", o_v, o_d); end
        rin = 1'b1;
        tick();
        checks++; if (dq.size() != 2 || dq[0] !== 32'h55 || dq[1] !== 32'h66) begin errs++; $display("FAIL ft_order: got n=%0d", dq.size()); end
    endtask

    task automatic test_flush_rst();
        sel = 2; do_reset(); rin = 1'b0;
        for (int k = 0; k < 3; k++) begin vin = 1'b1; din = 32'h30 + DW'(k); tick(); end
        flush = 1'b1; din = 32'h77;
        tick();
        flush = 1'b0; vin = 1'b0;
        #1;
        checks++; if (o_c !== 0 || o_v !== 1'b0 || o_r !== 1'b1) begin errs++; $display("FAIL flush_state: got c=%0d v=%b r=%b exp c=0 v=0 r=1", o_c, o_v, o_r); end
        rin = 1'b1;
        for (int c = 0; c < 4; c++) tick();
        checks++; if (dq.size() != 0) begin errs++; $display("FAIL flush_leak: got %0d beats exp 0", dq.size()); end
        rin = 1'b0;
        for (int k = 0; k < 2; k++) begin vin = 1'b1; din = 32'h40 + DW'(k); tick(); end
        vin = 1'b0; rst = 1'b1;
        #1;
        checks++; if (o_r !== 1'b0 || o_v !== 1'b0) begin errs++; $display("FAIL rst_mid_during: got r=%b v=%b exp r=0 v=0", o_r, o_v); end
        tick();
        rst = 1'b0;
        #1;
        checks++; if (o_c !== 0 || o_v !== 1'b0 || o_r !== 1'b1) begin errs++; $display("FAIL rst_mid_after: got c=%0d v=%b r=%b exp c=0 v=0 r=1", o_c, o_v, o_r); end
    endtask

    task automatic test_random(input int s);
        logic [DW-1:0] nxt;
        sel = s; do_reset(); nxt = 32'h1000 * DW'(s + 1);
        vin = 1'b0;
        for (int c = 0; c < 400; c++) begin
            bit acc;
            if (!vin) begin vin = ($urandom_range(0, 3) != 0); din = nxt; end
            rin = ($urandom_range(0, 2) != 0);
            flush = ($urandom_range(0, 39) == 0);
            #1;
            checks++; if (o_r !== m_ready() || o_v !== m_valid() || o_c !== m_cnt())
                begin errs++; $display("FAIL rand%0d_hs[%0d]: got r=%b v=%b c=%0d exp r=%b v=%b c=%0d", s, c, o_r, o_v, o_c, m_ready(), m_valid(), m_cnt()); end
            if (m_valid()) begin
                checks++; if (o_d !== m_data()) begin errs++; $display("FAIL rand%0d_data[%0d]: got %h exp %h", s, c, o_d, m_data()); end
            end
            acc = vin && o_r;
            tick();
            if (acc) begin vin = 1'b0; nxt = nxt + 1; end
        end
        flush = 1'b0;
    endtask

`ifdef AXI_ELASTIC_BUFFER_STATS_EN
    task automatic test_stats();
        sel = 2; do_reset(); rin = 1'b0;
        vin = 1'b1; din = 32'h1; tick();
        vin = 1'b0;
        for (int c = 0; c < 5; c++) tick();
        checks++; if (st[2] !== 32'd5) begin errs++; $display("FAIL stats_stall: got %0d exp 5", st[2]); end
        checks++; if (m2 !== 3'd1) begin errs++; $display("FAIL stats_max1: got %0d exp 1", m2); end
        for (int k = 0; k < 3; k++) begin vin = 1'b1; din = DW'(k); tick(); end
        vin = 1'b0; flush = 1'b1; tick(); flush = 1'b0;
        checks++; if (m2 !== 3'd4) begin errs++; $display("FAIL stats_max4: got %0d exp 4", m2); end
        checks++; if (st[2] !== 32'd0) begin errs++; $display("FAIL stats_flush: got %0d exp 0", st[2]); end
    endtask
`endif

    initial begin
        rst = 1'b1; vin = 1'b0; rin = 1'b0; flush = 1'b0; din = '0; sel = 2;
        test_reset();
        test_back_to_back();
        test_fill_drain();
        test_wrap();
        test_fallthrough();
        test_flush_rst();
        for (int s = 0; s < 4; s++) test_random(s);
`ifdef AXI_ELASTIC_BUFFER_STATS_EN
        test_stats();
`endif
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/axi_elastic_buffer.md
Name: axi_elastic_buffer

Overview:
- Parametrised successor to the single-stage spill register, used on AXI channel paths (AW/W/B/AR/R) in the crossbar.
- N-entry circular buffer with valid/ready handshake on both sides.
- Sustains one transfer per cycle at Depth>=2.
- Optional fall-through mode, synchronous flush and an occupancy output.

Parameters:
- DataWidth, 32, payload width in bits.
- Depth, 2, number of storage entries; legal range 1..64; Depth=1 halves throughput.
- FallThrough, 0, 0 = registered output with 1-cycle latency; 1 = empty-buffer bypass with 0-cycle latency.
- CntWidth, $clog2(Depth+1), derived; width of count_o. Do not override.

Ports:
- clk_i  input  1  clock; all logic on rising edge.
- rst_i  input  1  synchronous, active-high reset.
- flush_i  input  1  synchronous clear of all stored entries.
- valid_i  input  1  upstream valid.
- ready_o  output  1  upstream ready.
- data_i  input  DataWidth  upstream payload.
- valid_o  output  1  downstream valid.
- ready_i  input  1  downstream ready.
- data_o  output  DataWidth  downstream payload.
- count_o  output  CntWidth  number of stored entries.

Behaviour:
- Definitions: push = valid_i & ready_o; pop = valid_o & ready_i.
- Storage and pointers:
  - Storage is an array of Depth entries with write pointer wptr, read pointer rptr and counter cnt.
  - Pointers wrap from Depth-1 to 0; Depth need not be a power of two.
- Reset (rst_i=1 at a clock edge):
  - wptr=rptr=cnt=0 and all entries cleared to 0.
  - After reset: valid_o=0, data_o=0, count_o=0, ready_o=1.
  - While rst_i is high, ready_o is forced to 0 and valid_o to 0.
- ready_o = (cnt != Depth) & ~rst_i.
  - ready_o does not depend on ready_i; this cuts the ready path.
  - When full, ready_o=0 even if a pop occurs in the same cycle.
- FallThrough=0:
  - valid_o = (cnt != 0); data_o = mem[rptr].
  - A push in cycle t is visible at the output in cycle t+1.
- FallThrough=1:
  - If cnt==0, valid_o=valid_i and data_o=data_i (combinational).
  - If cnt==0 and valid_i & ready_i, the beat passes through and nothing is stored; cnt and pointers are unchanged.
  - If cnt==0 and valid_i & ~ready_i, the beat is stored.
  - If cnt!=0, behaviour is as FallThrough=0.
- Per edge, when not bypassed:
  - push: mem[wptr]<=data_i, wptr advances.
  - pop: rptr advances.
  - cnt <= cnt + push - pop; push and pop in the same cycle leave cnt unchanged.
- count_o = cnt (registered).
- flush_i=1 at an edge:
  - wptr=rptr=cnt=0; any push in that cycle is discarded.
  - A pop in that cycle is considered completed by the consumer.
  - Entry contents are not cleared.
  - rst_i has priority over flush_i.
- Stability: once valid_o=1, data_o and valid_o stay stable until pop, flush or reset.
  - Exception: FallThrough=1 bypass, where they follow upstream.
- Overflow and underflow are impossible by construction.
- Simulation assertions required:
  - cnt<=Depth.
  - No push when full.
  - valid_i held stable while ready_o=0 (upstream protocol check).

Optional Feature:
- Macro: AXI_ELASTIC_BUFFER_STATS_EN.
- When defined, the block adds:
  - Output stall_cnt_o [31:0]: increments each cycle valid_o & ~ready_i; saturates at 32'hFFFF_FFFF; cleared by rst_i or flush_i.
  - Output max_cnt_o [CntWidth-1:0]: high-water mark of cnt; cleared by rst_i only.
- When undefined, neither port exists and no counter logic is synthesised.

Test Plan:
- Depth=2, FallThrough=0, ready_i=1, stream 0x1..0x8 back-to-back:
  - 8 outputs in order, first at cycle+1.
  - valid_o continuous; count_o never exceeds 1.
- Depth=4, ready_i=0, push 0xA0..0xA5:
  - ready_o drops after 4 pushes; count_o=4; data_o=0xA0.
  - Raise ready_i: pops 0xA0..0xA3, then 0xA4 and 0xA5 are accepted in order.
- Depth=3, fill to 3, then hold push and pop active for 10 cycles:
  - ready_o stays 0 while full.
  - After the first pop, one push per cycle is accepted; no loss or duplication across pointer wrap.
- FallThrough=1, empty buffer, valid_i=1, data_i=0x55, ready_i=1:
  - valid_o=1 and data_o=0x55 in the same cycle; count_o stays 0.
  - Repeat with ready_i=0: count_o=1 next cycle.
- Depth=4 holding 3 entries, flush_i=1 together with push 0x77:
  - Next cycle count_o=0, valid_o=0, ready_o=1; 0x77 never emerges.
  - Mid-stream rst_i=1 gives the same state, with ready_o=0 during reset.
- STATS_EN, ready_i=0 for 5 cycles with valid_o=1: stall_cnt_o=5; max_cnt_o equals peak count_o.
